// File: rtl/time_set_ctrl.sv
// time_set_ctrl: debounced two-button editor for the HH:MM shadow time, with a commit strobe
// that loads the timekeeper and a blink mask for the digits being edited.
module time_set_ctrl #(
    parameter int DEB_CYCLES   = 80000,
    parameter int BLINK_CYCLES = 4000000
) (
    input  logic       pCLK,
    input  logic       nRST,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [3:0] cur_h1,
    input  logic [3:0] cur_h0,
    input  logic [3:0] cur_m1,
    input  logic [3:0] cur_m0,
    output logic [3:0] set_h1,
    output logic [3:0] set_h0,
    output logic [3:0] set_m1,
    output logic [3:0] set_m0,
    output logic       load,
    output logic       run_en,
    output logic [1:0] mode,
    output logic [3:0] blink_mask
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int BW = $clog2(BLINK_CYCLES + 1);

    typedef enum logic [1:0] {RUN = 2'd0, SET_HOUR = 2'd1, SET_MIN = 2'd2, COMMIT = 2'd3} state_t;

    logic [1:0] btn, prs;
    assign btn = {btn_inc, btn_mode};

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_deb
            logic s1, s2, deb, arm, p, mis;
            logic [DW-1:0] cnt;
            // Until a stable low has been seen, the counter times the low level instead, so a
            // button held through reset never yields a press.
            assign mis = arm ? (s2 != deb) : !s2;
            always_ff @(posedge pCLK or negedge nRST) begin
                if (!nRST) begin
                    s1  <= 1'b0;
                    s2  <= 1'b0;
                    deb <= 1'b0;
                    arm <= 1'b0;
                    p   <= 1'b0;
                    cnt <= '0;
                end else begin
                    s1 <= btn[g];
                    s2 <= s1;
                    p  <= 1'b0;
                    if (!mis)
                        cnt <= '0;
                    else if (cnt == DW'(DEB_CYCLES - 1)) begin
                        cnt <= '0;
                        if (arm) begin
                            deb <= s2;
                            p   <= s2;
                        end else
                            arm <= 1'b1;
                    end else
                        cnt <= cnt + 1'b1;
                end
            end
            assign prs[g] = p;
        end
    endgenerate

    logic mode_p, inc_p;
    assign mode_p = prs[0];
    assign inc_p  = prs[1];

    logic [3:0] nh1, nh0, nm1, nm0;
    logic       h_wrap;
    assign h_wrap = set_h1 == 4'd1 && set_h0 == 4'd1;
    assign nh1 = h_wrap ? 4'd0 : set_h0 == 4'd9 ? set_h1 + 4'd1 : set_h1;
    assign nh0 = (h_wrap || set_h0 == 4'd9) ? 4'd0 : set_h0 + 4'd1;
    assign nm0 = set_m0 == 4'd9 ? 4'd0 : set_m0 + 4'd1;
    assign nm1 = set_m0 != 4'd9 ? set_m1 : set_m1 == 4'd5 ? 4'd0 : set_m1 + 4'd1;

    state_t        st;
    logic [BW-1:0] bcnt;
    logic          ph, wrap;
    assign wrap = bcnt == BW'(BLINK_CYCLES - 1);
    assign mode = st;

    always_ff @(posedge pCLK or negedge nRST) begin
        if (!nRST) begin
            st         <= RUN;
            run_en     <= 1'b1;
            load       <= 1'b0;
            blink_mask <= 4'b0000;
            {set_h1, set_h0, set_m1, set_m0} <= '0;
            bcnt       <= '0;
            ph         <= 1'b0;
        end else begin
            load <= 1'b0;
            case (st)
                RUN:
                    if (mode_p) begin
                        st         <= SET_HOUR;
                        run_en     <= 1'b0;
                        {set_h1, set_h0, set_m1, set_m0} <= {cur_h1, cur_h0, cur_m1, cur_m0};
                        bcnt       <= '0;
                        ph         <= 1'b0;
                        blink_mask <= 4'b0000;
                    end
                SET_HOUR:
                    if (mode_p) begin
                        st         <= SET_MIN;
                        bcnt       <= '0;
                        ph         <= 1'b0;
                        blink_mask <= 4'b0000;
                    end else if (inc_p) begin
                        {set_h1, set_h0} <= {nh1, nh0};
                        bcnt       <= '0;
                        ph         <= 1'b0;
                        blink_mask <= 4'b0000;
                    end else if (wrap) begin
                        bcnt       <= '0;
                        ph         <= ~ph;
                        blink_mask <= {~ph, ~ph, 2'b00};
                    end else
                        bcnt <= bcnt + 1'b1;
                SET_MIN:
                    if (mode_p) begin
                        st         <= COMMIT;
                        load       <= 1'b1;
                        bcnt       <= '0;
                        ph         <= 1'b0;
                        blink_mask <= 4'b0000;
                    end else if (inc_p) begin
                        {set_m1, set_m0} <= {nm1, nm0};
                        bcnt       <= '0;
                        ph         <= 1'b0;
                        blink_mask <= 4'b0000;
                    end else if (wrap) begin
                        bcnt       <= '0;
                        ph         <= ~ph;
                        blink_mask <= {2'b00, ~ph, ~ph};
                    end else
                        bcnt <= bcnt + 1'b1;
                COMMIT: begin
                    st     <= RUN;
                    run_en <= 1'b1;
                end
            endcase
        end
    end
endmodule
